// File: rtl/mem_stage_access_pkg.sv
// Shared definitions for the MEM-stage access block.
// - MemtoReg encodings selecting the write-back source.
// - FSM state encoding for the data-memory access sequencer.
// - wb_select: the write-back multiplexer shared by the top module.
package mem_stage_access_pkg;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC4 = 2'd2;
  localparam logic [1:0] MTR_RES = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] wb_select(
    input logic [1:0]  sel,
    input logic [31:0] alu,
    input logic [31:0] mem,
    input logic [31:0] pc4,
    input logic [31:0] res
  );
    logic [31:0] r;
    case (sel)
      MTR_ALU: r = alu;
      MTR_MEM: r = mem;
      MTR_PC4: r = pc4;
      MTR_RES: r = res;
      default: r = alu;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_access_if.sv
// Data-memory req/ack bus between the MEM stage (master) and memory (slave).
// - bus_req/bus_we/bus_addr/bus_wdata : request side, stable while bus_req=1
// - bus_ack/bus_rdata/bus_err         : single-cycle completion from memory
interface mem_stage_access_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata, bus_err
  );
endinterface

// File: rtl/mem_timeout_counter.sv
// Saturating cycle counter used to bound the wait for a bus acknowledge.
// - clk, reset : clock and asynchronous active-high reset
// - clr        : synchronous clear (has priority over en)
// - en         : count enable
// - hit        : count has reached TIMEOUT_CYCLES-1
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] CNT_MAX  = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != CNT_MAX)) begin
      // Stops at the top value rather than wrapping back to zero.
      count_q <= count_q + 1'b1;
    end
  end

  assign hit = (count_q == CNT_LAST);

endmodule

// File: rtl/mem_stage_access.sv
// MEM pipeline stage: executes the load/store held in EX/MEM on the data
// bus, stalls upstream stages while the access is outstanding, and owns the
// MEM/WB register.
// - clk, reset           : clock, asynchronous active-high reset
// - ex_*                 : EX/MEM register contents (held by upstream while stalled)
// - bus                  : data-memory req/ack bus (master side)
// - stall                : freeze PC, IF/ID, ID/EX and EX/MEM
// - mem_err              : one-cycle pulse on misaligned access, bus error or timeout
// - wb_reg_write/wb_write_reg/wb_data : MEM/WB register
module mem_stage_access
  import mem_stage_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        ex_alu_result,
  input  logic [31:0]        ex_mem_wr_data,
  input  logic [4:0]         ex_write_reg,
  input  logic [31:0]        ex_pc_add4,
  input  logic [31:0]        ex_result,
  input  logic               ex_reg_write,
  input  logic [1:0]         ex_mem_to_reg,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  mem_stage_access_if.master bus,
  output logic               stall,
  output logic               mem_err,
  output logic               wb_reg_write,
  output logic [4:0]         wb_write_reg,
  output logic [31:0]        wb_data
);

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mem_err_q, mem_err_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic [4:0]  wb_write_reg_q, wb_write_reg_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        acc, mis, in_done, stall_int;
  logic        cnt_clr, cnt_en, cnt_hit;
  logic [31:0] mem_src;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .hit   (cnt_hit)
  );

  assign acc     = ex_mem_read | ex_mem_write;
  assign mis     = acc & (ex_alu_result[1:0] != 2'b00);
  assign in_done = (state_q == DONE);

  // Gated by reset so upstream is released the moment reset is applied,
  // even if a memory instruction is sitting in EX/MEM.
  assign stall_int = ~reset & (((state_q == IDLE) & acc & ~mis) | (state_q == BUSY));
  assign stall     = stall_int;

  // Memory data is only meaningful in DONE; elsewhere source 1 reads as zero.
  assign mem_src = in_done ? rdata_q : 32'h0;

  always_comb begin
    state_d        = state_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    mem_err_d      = 1'b0;
    wb_reg_write_d = wb_reg_write_q;
    wb_write_reg_d = wb_write_reg_q;
    wb_data_d      = wb_data_q;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;

    case (state_q)
      IDLE: begin
        if (acc && !mis) begin
          // Write wins when both read and write are requested.
          bus_we_d    = ex_mem_write;
          bus_addr_d  = {ex_alu_result[31:2], 2'b00};
          bus_wdata_d = ex_mem_wr_data;
          bus_req_d   = 1'b1;
          cnt_clr     = 1'b1;
          state_d     = BUSY;
        end else if (mis) begin
          mem_err_d = 1'b1;
        end
      end
      BUSY: begin
        if (bus.bus_ack) begin
          bus_req_d = 1'b0;
          rdata_d   = bus.bus_rdata;
          err_d     = bus.bus_err;
          state_d   = DONE;
        end else if (cnt_hit) begin
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        mem_err_d = err_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // MEM/WB: bubble while stalled, otherwise retire the EX/MEM instruction.
    // A misaligned or failed access retires without writing the register file.
    if (stall_int) begin
      wb_reg_write_d = 1'b0;
    end else begin
      wb_write_reg_d = ex_write_reg;
      wb_data_d      = wb_select(ex_mem_to_reg, ex_alu_result, mem_src,
                                 ex_pc_add4, ex_result);
      wb_reg_write_d = ex_reg_write & ~mis & ~(in_done & err_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= 32'h0;
      bus_wdata_q    <= 32'h0;
      rdata_q        <= 32'h0;
      err_q          <= 1'b0;
      mem_err_q      <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_write_reg_q <= 5'd0;
      wb_data_q      <= 32'h0;
    end else begin
      state_q        <= state_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      rdata_q        <= rdata_d;
      err_q          <= err_d;
      mem_err_q      <= mem_err_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_write_reg_q <= wb_write_reg_d;
      wb_data_q      <= wb_data_d;
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign mem_err       = mem_err_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_write_reg  = wb_write_reg_q;
  assign wb_data       = wb_data_q;

endmodule
